// File: rtl/fp_result_fifo_if.sv
// Handshake bundle between a float adder/subtractor result stream and its consumer.
// The slave modport is the FIFO view; the master modport is the producer/consumer view.
interface fp_result_fifo_if #(
    parameter int DEPTH = 4
);
    logic [31:0]              in_data;
    logic                     in_valid;
    logic [31:0]              out_data;
    logic [3:0]               out_flags;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_flags,
        output out_valid,
        output count,
        output overflow
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_flags,
        input  out_valid,
        input  count,
        input  overflow
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Show-ahead result FIFO that captures one entry per rising edge of in_valid.
// Optional macro FP_RESULT_CLASSIFY_EN adds per-entry {nan, inf, zero, denorm} flags.
module fp_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_result_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef FP_RESULT_CLASSIFY_EN
    localparam int ENTRY_W = 36;
`else
    localparam int ENTRY_W = 32;
`endif
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic               prev_valid_reg;
    logic               overflow_reg;
    logic               overflow_next;

    logic               capture;
    logic               is_full;
    logic               is_empty;
    logic               do_push;
    logic               do_pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign capture  = bus.in_valid & ~prev_valid_reg;
    assign is_full  = (count_reg == FULL_COUNT);
    assign is_empty = (count_reg == '0);
    assign do_pop   = ~rst & ~is_empty & bus.out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push  = ~rst & capture & (~is_full | do_pop);

`ifdef FP_RESULT_CLASSIFY_EN
    logic [7:0]  exp_field;
    logic [22:0] man_field;
    logic [3:0]  in_flags;

    assign exp_field = bus.in_data[30:23];
    assign man_field = bus.in_data[22:0];
    assign in_flags  = {(exp_field == 8'hFF) && (man_field != '0),
                        (exp_field == 8'hFF) && (man_field == '0),
                        (exp_field == 8'h00) && (man_field == '0),
                        (exp_field == 8'h00) && (man_field != '0)};
    assign wr_entry  = {in_flags, bus.in_data};
`else
    assign wr_entry  = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_entry;
        end
    end

    always_comb begin
        count_next    = count_reg;
        overflow_next = overflow_reg | (capture & is_full & ~do_pop);
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers are AW bits wide, so incrementing past DEPTH-1 wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            prev_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            prev_valid_reg <= bus.in_valid;
            count_reg      <= count_next;
            overflow_reg   <= overflow_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Outputs read the stored head only; empty forces zero so reset shows clean data.
    assign head_entry    = mem_reg[rd_ptr_reg];
    assign bus.out_data  = is_empty ? 32'h0 : head_entry[31:0];
`ifdef FP_RESULT_CLASSIFY_EN
    assign bus.out_flags = is_empty ? 4'b0000 : head_entry[35:32];
`else
    assign bus.out_flags = 4'b0000;
`endif
    assign bus.out_valid = ~is_empty;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_fp_result_fifo.sv
// Directed scoreboard bench for fp_result_fifo (DEPTH = 4).
// Expected entries are queued when a capture is driven and compared when popped.
module tb_fp_result_fifo;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fp_result_fifo_if #(.DEPTH(DEPTH)) bus ();

    fp_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q [$];
    logic        exp_ovf = 1'b0;

    function automatic logic [3:0] cls(input logic [31:0] d);
        logic [3:0] f;
        f = 4'b0000;
`ifdef FP_RESULT_CLASSIFY_EN
        if (d[30:23] == 8'hFF) f = (d[22:0] != 0) ? 4'b1000 : 4'b0100;
        else if (d[30:23] == 8'h00) f = (d[22:0] == 0) ? 4'b0010 : 4'b0001;
`endif
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One capture with out_ready low, followed by a low cycle to re-arm edge detection.
    task automatic push_one(input logic [31:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back({cls(d), d});
        else exp_ovf = 1'b1;
        step();
        $display("push data=%08h count=%0d overflow=%0b", d, bus.count, bus.overflow);
        check("push_count", 64'(bus.count), 64'(exp_q.size()));
        check("push_overflow", 64'(bus.overflow), 64'(exp_ovf));
    endtask

    task automatic pop_one();
        logic [35:0] e;
        e = exp_q.pop_front();
        $display("pop  data=%08h flags=%04b", bus.out_data, bus.out_flags);
        check("pop_valid", 64'(bus.out_valid), 64'(1));
        check("pop_data", 64'(bus.out_data), 64'(e[31:0]));
        check("pop_flags", 64'(bus.out_flags), 64'(e[35:32]));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("pop_count", 64'(bus.count), 64'(exp_q.size()));
    endtask

    task automatic check_reset_state(input string tag);
        $display("reset %s count=%0d valid=%0b ovf=%0b data=%08h", tag, bus.count, bus.out_valid, bus.overflow, bus.out_data);
        check({tag, "_count"}, 64'(bus.count), 64'(0));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_overflow"}, 64'(bus.overflow), 64'(0));
        check({tag, "_data"}, 64'(bus.out_data), 64'(0));
        check({tag, "_flags"}, 64'(bus.out_flags), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cls_vals [4];
        logic [31:0] d;
        cls_vals[0] = 32'hFFFFFFFF;
        cls_vals[1] = 32'h7F800000;
        cls_vals[2] = 32'h80000000;
        cls_vals[3] = 32'h00000001;

        rst           = 1'b1;
        bus.in_data   = 32'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("init");

        // Capture and hold: one push despite five cycles of in_valid.
        bus.in_data  = 32'h40400000;
        bus.in_valid = 1'b1;
        step();
        exp_q.push_back({cls(32'h40400000), 32'h40400000});
        check("hold_first_count", 64'(bus.count), 64'(1));
        check("hold_first_data", 64'(bus.out_data), 64'(32'h40400000));
        repeat (4) step();
        $display("hold count=%0d data=%08h flags=%04b", bus.count, bus.out_data, bus.out_flags);
        check("hold_count", 64'(bus.count), 64'(1));
        check("hold_flags", 64'(bus.out_flags), 64'(4'b0000));
        bus.in_valid = 1'b0;
        step();
        pop_one();

        // Classification of special values.
        for (int i = 0; i < 4; i++) push_one(cls_vals[i]);
        for (int i = 0; i < 4; i++) pop_one();

        // Overflow: fifth push is dropped and sticky flag set.
        for (int i = 0; i < 5; i++) push_one(32'h3F800000 + 32'(i));
        check("ovf_count", 64'(bus.count), 64'(DEPTH));
        for (int i = 0; i < 4; i++) pop_one();
        check("ovf_empty_valid", 64'(bus.out_valid), 64'(0));
        check("ovf_sticky", 64'(bus.overflow), 64'(1));

        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ovf = 1'b0;
        check_reset_state("clr");

        // Full with simultaneous push and pop, crossing pointer wrap.
        for (int i = 0; i < 4; i++) push_one(32'h41000000 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            logic [35:0] e;
            d = 32'hC1000000 + 32'(i);
            e = exp_q.pop_front();
            check("full_pp_data", 64'(bus.out_data), 64'(e[31:0]));
            bus.in_data   = d;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            step();
            exp_q.push_back({cls(d), d});
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            step();
            $display("fullpp in=%08h count=%0d ovf=%0b", d, bus.count, bus.overflow);
            check("full_pp_count", 64'(bus.count), 64'(DEPTH));
            check("full_pp_overflow", 64'(bus.overflow), 64'(0));
        end
        for (int i = 0; i < 4; i++) pop_one();

        // Reset mid-operation wins over push/pop; in_valid held through reset captures after.
        for (int i = 0; i < 3; i++) push_one(32'h42000000 + 32'(i));
        check("mid_count3", 64'(bus.count), 64'(3));
        rst           = 1'b1;
        bus.in_data   = 32'h42C80000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        exp_q.delete();
        check_reset_state("mid");
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        step();
        exp_q.push_back({cls(32'h42C80000), 32'h42C80000});
        check("post_rst_count", 64'(bus.count), 64'(1));
        check("post_rst_data", 64'(bus.out_data), 64'(32'h42C80000));
        bus.in_valid = 1'b0;
        step();
        pop_one();

        // Empty pop is ignored.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            $display("emptypop cycle=%0d count=%0d valid=%0b", i, bus.count, bus.out_valid);
            check("empty_count", 64'(bus.count), 64'(0));
            check("empty_valid", 64'(bus.out_valid), 64'(0));
        end
        bus.out_ready = 1'b0;
        push_one(32'h40A00000);
        pop_one();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
